// File: rtl/alu_arb2.sv
// Two-requester round-robin front end for a single shared 16-bit ALU.
// It grants one requester, captures its operands, runs the ALU once and returns a registered result.
module alu_arb2 #(
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [1:0]  op0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [1:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] y,
  output logic        cout,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StDone = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        pri_q, pri_d;
  logic        owner_q, owner_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [1:0]  opc_q, opc_d;
  logic [15:0] y_q, y_d;
  logic        cout_q, cout_d;

  logic        grant;
  logic        grant_sel;
  logic [15:0] alu_b;
  logic [16:0] alu_sum;
  logic [15:0] alu_y;
  logic        alu_cout;

  // alu16: op[0] inverts b and supplies the carry-in, so sub is a + ~b + 1
  always_comb begin
    alu_b    = opc_q[0] ? ~opb_q : opb_q;
    alu_sum  = {1'b0, opa_q} + {1'b0, alu_b} + {16'd0, opc_q[0]};
    alu_y    = 16'd0;
    alu_cout = 1'b0;
    unique case (opc_q)
      2'b00, 2'b01: begin
        alu_y    = alu_sum[15:0];
        alu_cout = alu_sum[16];
      end
      2'b10:   alu_y = opa_q & opb_q;
      default: alu_y = opa_q | opb_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pri_q   <= FIRST_PRI;
      owner_q <= 1'b0;
      opa_q   <= 16'd0;
      opb_q   <= 16'd0;
      opc_q   <= 2'd0;
      y_q     <= 16'd0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    grant     = req0 | req1;
    grant_sel = (req0 & req1) ? pri_q : req1;
    state_d   = state_q;
    pri_d     = pri_q;
    owner_d   = owner_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    y_d       = y_q;
    cout_d    = cout_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = grant_sel;
          opa_d   = grant_sel ? a1 : a0;
          opb_d   = grant_sel ? b1 : b0;
          opc_d   = grant_sel ? op1 : op0;
          state_d = StExec;
        end
      end
      StExec: begin
        y_d     = alu_y;
        cout_d  = opc_q[1] ? 1'b0 : alu_cout;
        state_d = StDone;
      end
      StDone: begin
        pri_d   = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack0  = (state_q == StExec) && !owner_q;
    ack1  = (state_q == StExec) && owner_q;
    done0 = (state_q == StDone) && !owner_q;
    done1 = (state_q == StDone) && owner_q;
    busy  = (state_q != StIdle);
    y     = y_q;
    cout  = cout_q;
  end

endmodule

// File: tb/tb_alu_arb2.sv
// Scoreboard bench for alu_arb2: drivers push expected results, a negedge monitor pops and compares.
module tb_alu_arb2;

  localparam bit FIRST_PRI = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        ack0, ack1, done0, done1, cout, busy;
  logic [15:0] y;
  logic [1:0]  ack, done;

  assign ack  = {ack1, ack0};
  assign done = {done1, done0};

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int          dlog_r[$];
  int          dlog_c[$];
  logic        pri_m = FIRST_PRI;
  logic [1:0]  prev_ack = 2'b00;

  alu_arb2 #(.FIRST_PRI(FIRST_PRI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req[0]),
    .a0    (a0),
    .b0    (b0),
    .op0   (op0),
    .req1  (req[1]),
    .a1    (a1),
    .b1    (b1),
    .op1   (op1),
    .ack0  (ack0),
    .ack1  (ack1),
    .done0 (done0),
    .done1 (done1),
    .y     (y),
    .cout  (cout),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: {cout, y} from plain arithmetic on the operands
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    int unsigned s;
    case (op)
      2'd0: begin
        s = 32'(a) + 32'(b);
        return {s[16], s[15:0]};
      end
      2'd1:    return {a >= b, a - b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Monitor: sampled on the falling edge; drivers only change inputs 1 time unit after it
  initial begin
    logic        exp_w;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pri_m    = FIRST_PRI;
        prev_ack = 2'b00;
      end else begin
        if (ack != 2'b00 || prev_ack != 2'b00) check("done_follows_ack", 32'(done), 32'(prev_ack));
        check("busy", 32'(busy), 32'((ack | done) != 2'b00));
        if (ack != 2'b00) begin
          exp_w = (req == 2'b11) ? pri_m : req[1];
          check("grant", 32'(ack), exp_w ? 32'd2 : 32'd1);
          pri_m = ~ack[1];
        end
        if (done[0]) begin
          if (q0.size() == 0) check("unexpected_done0", 32'(done[0]), 32'd0);
          else begin
            e = q0.pop_front();
            check("y0", 32'(y), 32'(e[15:0]));
            check("cout0", 32'(cout), 32'(e[16]));
          end
        end
        if (done[1]) begin
          if (q1.size() == 0) check("unexpected_done1", 32'(done[1]), 32'd0);
          else begin
            e = q1.pop_front();
            check("y1", 32'(y), 32'(e[15:0]));
            check("cout1", 32'(cout), 32'(e[16]));
          end
        end
        if (done[0]) begin dlog_r.push_back(0); dlog_c.push_back(cyc); end
        if (done[1]) begin dlog_r.push_back(1); dlog_c.push_back(cyc); end
        prev_ack = ack;
      end
    end
  end

  task automatic do_req(input int r, input logic [15:0] av, input logic [15:0] bv,
                        input logic [1:0] opv);
    int n;
    if (r == 0) begin
      a0 = av; b0 = bv; op0 = opv;
      q0.push_back(model(av, bv, opv));
    end else begin
      a1 = av; b1 = bv; op1 = opv;
      q1.push_back(model(av, bv, opv));
    end
    req[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ack[r] && n < 20) begin n++; @(negedge clk); end
    check($sformatf("ack%0d_seen", r), 32'(ack[r]), 32'd1);
    if (!ack[r]) begin
      req[r] = 1'b0;
      return;
    end
    #1;
    // Operands are free after ack; trash them to prove they were captured
    if (r == 0) begin a0 = 16'h0000; b0 = 16'($urandom); op0 = 2'($urandom); end
    else begin a1 = 16'h0000; b1 = 16'($urandom); op1 = 2'($urandom); end
    n = 0;
    @(negedge clk);
    while (!done[r] && n < 5) begin n++; @(negedge clk); end
    check($sformatf("done%0d_seen", r), 32'(done[r]), 32'd1);
    #1 req[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_y", 32'(y), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_done", 32'({ack, done}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    #1;

    // Directed arithmetic and logic cases
    do_req(0, 16'h1234, 16'h0001, 2'b00);
    do_req(1, 16'hFFFF, 16'h0001, 2'b00);
    do_req(1, 16'h0005, 16'h0007, 2'b01);
    do_req(1, 16'h0005, 16'h0003, 2'b01);
    do_req(0, 16'hF0F0, 16'h3C3C, 2'b10);
    do_req(0, 16'hF0F0, 16'h3C3C, 2'b11);

    // Simultaneous rise after reset: requester 0 first, requester 1 three cycles later
    do_reset();
    s = dlog_r.size();
    fork
      do_req(0, 16'h0102, 16'h0304, 2'b00);
      do_req(1, 16'h0900, 16'h0100, 2'b01);
    join
    if (dlog_r.size() < s + 2) check("both_count", 32'(dlog_r.size()), 32'(s + 2));
    else begin
      check("both_first", 32'(dlog_r[s]), 32'd0);
      check("both_second", 32'(dlog_r[s + 1]), 32'd1);
      check("both_gap", 32'(dlog_c[s + 1] - dlog_c[s]), 32'd3);
    end

    // Continuous contention: strict alternation, one idle cycle between operations
    s = dlog_r.size();
    fork
      for (int i = 0; i < 4; i++) do_req(0, 16'($urandom), 16'($urandom), 2'($urandom));
      for (int i = 0; i < 4; i++) do_req(1, 16'($urandom), 16'($urandom), 2'($urandom));
    join
    if (dlog_r.size() < s + 8) check("alt_count", 32'(dlog_r.size()), 32'(s + 8));
    else begin
      for (int k = 0; k < 8; k++) check("alt_order", 32'(dlog_r[s + k]), 32'(k % 2));
      for (int k = 1; k < 8; k++) check("alt_gap", 32'(dlog_c[s + k] - dlog_c[s + k - 1]), 32'd3);
    end

    // Randomized traffic with idle gaps
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1 do_req(0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1 do_req(1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      end
    join

    // Reset during EXEC aborts the operation
    do_req(0, 16'h1234, 16'h0001, 2'b00);
    a0 = 16'h00FF; b0 = 16'h0F00; op0 = 2'b11;
    req[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ack[0] && n < 20) begin n++; @(negedge clk); end
    check("abort_ack_seen", 32'(ack[0]), 32'd1);
    #1 rst_n = 1'b0;
    q0.delete();
    #1;
    check("abort_y", 32'(y), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack_done", 32'({ack, done}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_busy_hold", 32'(busy), 32'd0);
    end
    q0.push_back(model(16'h00FF, 16'h0F00, 2'b11));
    #1 rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done[0] && n < 10) begin n++; @(negedge clk); end
    check("after_reset_done0", 32'(done[0]), 32'd1);
    #1 req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("leftover_q", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
